// File: rtl/bin_to_bcd_conv.sv
// Sequential signed-binary to 8-digit BCD converter using shift-add-3.
// Digits, sign and overflow are registered together so a display can sample them at any time.
module bin_to_bcd_conv #(
   parameter int WIDTH   = 28,
   parameter int MAX_MAG = 99_999_999
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [3:0]       uni,
   output logic [3:0]       ten,
   output logic [3:0]       hun,
   output logic [3:0]       tho,
   output logic [3:0]       tt,
   output logic [3:0]       ht,
   output logic [3:0]       mil,
   output logic [3:0]       tmil,
   output logic             negative,
   output logic             overflow,
   output logic [1:0]       fsm_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH:0] MAX_MAG_W = (WIDTH+1)'(MAX_MAG);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] mag;
   logic [31:0]      bcd;
   logic [CW-1:0]    cnt;
   logic             sgn;
   logic             ovf;
   logic             lost;

   logic [WIDTH:0]   value_ext;
   logic [WIDTH:0]   mag_next;
   logic [31:0]      bcd_adj;

   // One extra bit so the most negative operand has an exact magnitude.
   always_comb begin
      value_ext = {value_q[WIDTH-1], value_q};
      mag_next  = value_q[WIDTH-1] ? (~value_ext + 1'b1) : value_ext;
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 8; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         value_q  <= '0;
         mag      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         sgn      <= 1'b0;
         ovf      <= 1'b0;
         lost     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         uni      <= '0;
         ten      <= '0;
         hun      <= '0;
         tho      <= '0;
         tt       <= '0;
         ht       <= '0;
         mil      <= '0;
         tmil     <= '0;
         negative <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  value_q <= value;
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               mag   <= mag_next[WIDTH-1:0];
               sgn   <= value_q[WIDTH-1];
               ovf   <= (mag_next > MAX_MAG_W);
               bcd   <= '0;
               lost  <= 1'b0;
               cnt   <= CW'(WIDTH-1);
               state <= SHIFT;
            end
            SHIFT: begin
               // Carry out of the top digit only occurs for out-of-range magnitudes.
               bcd  <= {bcd_adj[30:0], mag[WIDTH-1]};
               mag  <= {mag[WIDTH-2:0], 1'b0};
               lost <= lost | bcd_adj[31];
               if (cnt == '0) begin
                  state <= FIN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIN: begin
               if (ovf || lost) begin
                  {tmil, mil, ht, tt, tho, hun, ten, uni} <= '0;
               end else begin
                  {tmil, mil, ht, tt, tho, hun, ten, uni} <= bcd;
               end
               negative <= sgn;
               overflow <= ovf;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   digits_in_range: assert property (@(posedge clk) disable iff (reset)
      (uni <= 4'd9) && (ten <= 4'd9) && (hun <= 4'd9) && (tho <= 4'd9) &&
      (tt <= 4'd9) && (ht <= 4'd9) && (mil <= 4'd9) && (tmil <= 4'd9));

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Directed bench for bin_to_bcd_conv: stimulus pushes expected results, a monitor checks each done.
module tb_bin_to_bcd_conv;
   localparam int WIDTH = 28;
   localparam int LAT   = WIDTH + 3;
   localparam int NV    = 14;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] value;
   logic             busy, done, negative, overflow;
   logic [3:0]       uni, ten, hun, tho, tt, ht, mil, tmil;
   logic [1:0]       fsm_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [33:0] exp_q[$];
   int          done_q[$];

   int          tv_val[NV] = '{12345678, -1, 0, 99999999, 100000000, -134217728, 134217727,
                               -99999999, -100000000, 5, 10, 90817263, -40302010, 1000000};
   logic [31:0] tv_bcd[NV] = '{32'h12345678, 32'h00000001, 32'h0, 32'h99999999, 32'h0, 32'h0, 32'h0,
                               32'h99999999, 32'h0, 32'h5, 32'h10, 32'h90817263, 32'h40302010, 32'h01000000};
   logic        tv_neg[NV] = '{0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0};
   logic        tv_ovf[NV] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};

   bin_to_bcd_conv #(.WIDTH(WIDTH), .MAX_MAG(99_999_999)) dut (
      .clk(clk), .reset(reset), .start(start), .value(value),
      .busy(busy), .done(done),
      .uni(uni), .ten(ten), .hun(hun), .tho(tho), .tt(tt), .ht(ht), .mil(mil), .tmil(tmil),
      .negative(negative), .overflow(overflow), .fsm_state(fsm_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest expected entry, at the expected cycle.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         logic [33:0] got;
         logic [33:0] e;
         int          dc;
         logic        ok;
         got = {tmil, mil, ht, tt, tho, hun, ten, uni, negative, overflow};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            e  = exp_q.pop_front();
            dc = done_q.pop_front();
            check("result", got, e);
            check("latency", 34'(cyc), 34'(dc));
            check("busy_at_done", 34'(busy), 34'(0));
            ok = 1'b1;
            for (int i = 0; i < 8; i++) if (got[2 + 4*i +: 4] > 4'd9) ok = 1'b0;
            check("digit_range", 34'(ok), 34'(1));
         end
      end
   end

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
         exp_q.delete();
         done_q.delete();
      end
      @(negedge clk);
   endtask

   // Driver: one start pulse, expected result pushed at the accepting edge.
   task automatic convert(input int v, input logic [31:0] b, input logic neg, input logic ovf);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      value = WIDTH'(v);
      start = 1'b1;
      exp_q.push_back({b, neg, ovf});
      done_q.push_back(cyc + LAT);
      @(negedge clk);
      start = 1'b0;
      value = WIDTH'(32'h0ABCDEF);
      check("busy_after_accept", 34'(busy), 34'(1));
      wait_drain("convert");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      value = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {busy, done, tmil, mil, ht, tt, tho, hun, ten, uni, negative, overflow}, 34'(0));
      reset = 1'b0;

      for (int i = 0; i < NV; i++) convert(tv_val[i], tv_bcd[i], tv_neg[i], tv_ovf[i]);

      // start held high with value toggling: accepts land 31 cycles apart
      @(negedge clk);
      exp_q.push_back({32'h24681357, 1'b0, 1'b0});
      done_q.push_back(cyc + LAT);
      exp_q.push_back({32'h00013579, 1'b1, 1'b0});
      done_q.push_back(cyc + 2*LAT);
      exp_q.push_back({32'h24681357, 1'b0, 1'b0});
      done_q.push_back(cyc + 3*LAT);
      start = 1'b1;
      for (int i = 0; i < 2*LAT + 1; i++) begin
         value = (i % 2 == 0) ? WIDTH'(24681357) : WIDTH'(-13579);
         @(negedge clk);
      end
      start = 1'b0;
      wait_drain("back_to_back");

      // reset in the middle of SHIFT: no done, outputs cleared
      value = WIDTH'(55555555);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_cleared", {busy, done, tmil, mil, ht, tt, tho, hun, ten, uni, negative, overflow}, 34'(0));
      repeat (40) @(negedge clk);
      convert(87654321, 32'h87654321, 1'b0, 1'b0);

      // reset and start on the same edge: start is lost
      reset = 1'b1;
      start = 1'b1;
      value = WIDTH'(5);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("reset_beats_start", 34'(busy), 34'(0));
      repeat (40) @(negedge clk);
      convert(-7, 32'h7, 1'b1, 1'b0);

      check("queue_drained", 34'(exp_q.size()), 34'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
